// File: rtl/jtcop_objdma.sv
// Object RAM (CPU side) with a DMA engine that copies it into the object buffer
// read by the video side. One word is copied per clock, with a pipelined write.
module jtcop_objdma (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  cpu_addr,
  input  logic [15:0] cpu_dout,
  input  logic        UDSWn,
  input  logic        LDSWn,
  input  logic        obj_cs,
  input  logic        obj_copy,
  output logic [15:0] obj_dout,
  input  logic [9:0]  buf_addr,
  output logic [15:0] buf_data,
  output logic        dma_busy,
  output logic        dma_done
);

  typedef enum logic [1:0] {IDLE, COPY, LAST, RESTART} state_t;

  state_t      st;
  logic [9:0]  cnt;
  logic [9:0]  wr_addr;
  logic [15:0] rd_data;
  logic        wr_vld;
  logic        pending;
  logic        copy_q;
  logic        armed;
  logic        rise;

  logic [15:0] obj_ram [1024];
  logic [15:0] buf_ram [1024];

  // armed stays low for the first clock after reset so a level already high
  // at release is absorbed into copy_q instead of looking like an edge.
  assign rise = armed & obj_copy & ~copy_q;

  always_ff @(posedge clk) begin
    if (obj_cs && !UDSWn) obj_ram[cpu_addr][15:8] <= cpu_dout[15:8];
    if (obj_cs && !LDSWn) obj_ram[cpu_addr][7:0]  <= cpu_dout[7:0];
    if (wr_vld) buf_ram[wr_addr] <= rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      cnt      <= '0;
      wr_addr  <= '0;
      rd_data  <= '0;
      wr_vld   <= 1'b0;
      pending  <= 1'b0;
      copy_q   <= 1'b0;
      armed    <= 1'b0;
      dma_busy <= 1'b0;
      dma_done <= 1'b0;
      obj_dout <= '0;
      buf_data <= '0;
    end else begin
      armed    <= 1'b1;
      copy_q   <= obj_copy;
      obj_dout <= obj_ram[cpu_addr];
      buf_data <= buf_ram[buf_addr];
      wr_vld   <= 1'b0;
      dma_done <= 1'b0;
      case (st)
        IDLE: begin
          if (rise) begin
            st       <= COPY;
            cnt      <= '0;
            dma_busy <= 1'b1;
          end
        end
        COPY: begin
          rd_data <= obj_ram[cnt];
          wr_addr <= cnt;
          wr_vld  <= 1'b1;
          if (rise) pending <= 1'b1;
          if (cnt == '1) st <= LAST;
          else           cnt <= cnt + 10'd1;
        end
        LAST: begin
          // final buffer write lands at the end of this cycle
          dma_busy <= 1'b0;
          dma_done <= 1'b1;
          if (pending || rise) begin
            st      <= RESTART;
            pending <= 1'b0;
          end else begin
            st <= IDLE;
          end
        end
        RESTART: begin
          st       <= COPY;
          cnt      <= '0;
          dma_busy <= 1'b1;
          if (rise) pending <= 1'b1;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
